sccb_target: RTL

- SCCB target (camera-side responder) that sits at the other end of the 2-wire SCCB bus from the FPGA SCCB master.
- Oversamples SIO_C/SIO_D on XCLK, decodes start/stop conditions, and serves 3-phase writes, 2-phase writes and 2-phase reads against an internal 8-bit register bank.
- Serves as a loopback camera model for master bring-up. Also usable as an FPGA-resident SCCB-controlled config block.

---
 rtl/sccb_target.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/sccb_target.sv
// SCCB target: oversampled 2-wire responder with an 8-bit register bank.
// Optional macro SCCB_ACK_EN: drive an I2C-style ACK (SIO_D low) during the X bit.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | bus idle, waiting for start
// S_ID     | shifting in device ID byte
// S_SUB    | shifting in sub-address byte
// S_WR     | shifting in write data byte
// S_RD     | driving read data byte onto SIO_D
// S_IGNORE | transaction ignored, waiting for stop or start
module sccb_target #(
    parameter logic [7:0] DEV_ID    = 8'h42,
    parameter int         NUM_REGS  = 16,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic       XCLK,
    input  logic       RST_N,
    input  logic       SIO_C,
    input  logic       SIO_DI,
    output logic       SIO_DO,
    output logic       SIO_DE,
    input  logic [7:0] host_addr,
    output logic [7:0] host_rdata,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ID,
        S_SUB,
        S_WR,
        S_RD,
        S_IGNORE
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  sioc_q, siod_q;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_in_q, shift_in_d;
    logic [7:0]  shift_out_q, shift_out_d;
    logic [7:0]  sub_ptr_q, sub_ptr_d;
    logic        id_match_q, id_match_d;
    logic        id_rd_q, id_rd_d;
    logic        do_q, do_d;
    logic        de_q, de_d;
    logic        ack_q, ack_d;
    logic        busy_q, busy_d;
    logic        wr_strobe_q, wr_strobe_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        reg_we;
    logic [7:0]  ptr_rdata;
    logic [7:0]  regs_q [NUM_REGS];

    logic scl, sda, scl_rise, scl_fall, start_det, stop_det;

    function automatic logic in_range(input logic [7:0] a);
        in_range = ({1'b0, a} < 9'(NUM_REGS));
    endfunction

    // Sync flops reset to the idle-high bus level so reset never fakes a start.
    always_ff @(posedge XCLK or negedge RST_N) begin
        if (!RST_N) begin
            sioc_q <= 3'b111;
            siod_q <= 3'b111;
        end else begin
            sioc_q <= {sioc_q[1:0], SIO_C};
            siod_q <= {siod_q[1:0], SIO_DI};
        end
    end

    assign scl       = sioc_q[1];
    assign sda       = siod_q[1];
    assign scl_rise  = scl & ~sioc_q[2];
    assign scl_fall  = ~scl & sioc_q[2];
    assign start_det = scl & siod_q[2] & ~sda;
    assign stop_det  = scl & ~siod_q[2] & sda;

    always_comb begin
        ptr_rdata = 8'h00;
        if (in_range(sub_ptr_q)) begin
            ptr_rdata = regs_q[sub_ptr_q[AW-1:0]];
        end
    end

    always_comb begin
        host_rdata = 8'h00;
        if (in_range(host_addr)) begin
            host_rdata = regs_q[host_addr[AW-1:0]];
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_in_d  = shift_in_q;
        shift_out_d = shift_out_q;
        sub_ptr_d   = sub_ptr_q;
        id_match_d  = id_match_q;
        id_rd_d     = id_rd_q;
        do_d        = do_q;
        de_d        = de_q;
        ack_d       = ack_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        reg_we      = 1'b0;

        if (start_det) begin
            state_d   = S_ID;
            bit_cnt_d = 4'd0;
            busy_d    = 1'b1;
            de_d      = 1'b0;
            do_d      = 1'b1;
            ack_d     = 1'b0;
        end else if (stop_det) begin
            state_d   = S_IDLE;
            bit_cnt_d = 4'd0;
            busy_d    = 1'b0;
            de_d      = 1'b0;
            do_d      = 1'b1;
            ack_d     = 1'b0;
        end else begin
            if (scl_fall && ack_q) begin
                de_d  = 1'b0;
                do_d  = 1'b1;
                ack_d = 1'b0;
            end
            case (state_q)
                S_ID, S_SUB, S_WR: begin
                    if (scl_rise) begin
                        if (bit_cnt_q != 4'd8) begin
                            shift_in_d = {shift_in_q[6:0], sda};
                            bit_cnt_d  = bit_cnt_q + 4'd1;
                            if (state_q == S_ID && bit_cnt_q == 4'd7) begin
                                id_match_d = (shift_in_q[6:0] == DEV_ID[7:1]);
                                id_rd_d    = sda;
                            end
                        end else begin
                            bit_cnt_d = 4'd0;
                            case (state_q)
                                S_ID: begin
                                    if (!id_match_q) state_d = S_IGNORE;
                                    else if (id_rd_q) state_d = S_RD;
                                    else              state_d = S_SUB;
                                end
                                S_SUB: begin
                                    sub_ptr_d = shift_in_q;
                                    state_d   = S_WR;
                                end
                                default: begin
                                    if (in_range(sub_ptr_q)) begin
                                        reg_we      = 1'b1;
                                        wr_strobe_d = 1'b1;
                                        wr_addr_d   = sub_ptr_q;
                                        wr_data_d   = shift_in_q;
                                    end
                                    state_d = S_IGNORE;
                                end
                            endcase
                        end
                    end
`ifdef SCCB_ACK_EN
                    else if (scl_fall && bit_cnt_q == 4'd8 &&
                             (state_q != S_ID || id_match_q)) begin
                        de_d  = 1'b1;
                        do_d  = 1'b0;
                        ack_d = 1'b1;
                    end
`endif
                end
                S_RD: begin
                    // bit_cnt counts falling edges here; the 9th releases the bus for NA.
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd0) begin
                            shift_out_d = {ptr_rdata[6:0], 1'b0};
                            do_d        = ptr_rdata[7];
                            de_d        = 1'b1;
                            bit_cnt_d   = 4'd1;
                        end else if (bit_cnt_q != 4'd8) begin
                            shift_out_d = {shift_out_q[6:0], 1'b0};
                            do_d        = shift_out_q[7];
                            bit_cnt_d   = bit_cnt_q + 4'd1;
                        end else begin
                            de_d      = 1'b0;
                            do_d      = 1'b1;
                            bit_cnt_d = 4'd0;
                            state_d   = S_IGNORE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge XCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_in_q  <= 8'h00;
            shift_out_q <= 8'h00;
            sub_ptr_q   <= 8'h00;
            id_match_q  <= 1'b0;
            id_rd_q     <= 1'b0;
            do_q        <= 1'b1;
            de_q        <= 1'b0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 8'h00;
            wr_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_in_q  <= shift_in_d;
            shift_out_q <= shift_out_d;
            sub_ptr_q   <= sub_ptr_d;
            id_match_q  <= id_match_d;
            id_rd_q     <= id_rd_d;
            do_q        <= do_d;
            de_q        <= de_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    always_ff @(posedge XCLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else if (reg_we) begin
            regs_q[sub_ptr_q[AW-1:0]] <= shift_in_q;
        end
    end

    assign SIO_DO    = do_q;
    assign SIO_DE    = de_q & ~(start_det | stop_det);
    assign busy      = busy_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

endmodule
